// File: rtl/board_reveal_ctrl.sv
// Cursor and reveal sequencer for the 8x8 Buscaminas board: moves the cursor,
// counts neighbour mines through a 1-cycle-latency bitmap port and tracks lose/win.
module board_reveal_ctrl #(
  parameter int N     = 8,
  parameter int MINES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mv_up,
  input  logic       mv_down,
  input  logic       mv_left,
  input  logic       mv_right,
  input  logic       sel,
  input  logic       restart,
  output logic [2:0] casilla_x,
  output logic [2:0] casilla_y,
  output logic       mem_rd_en,
  output logic [2:0] mem_rd_x,
  output logic [2:0] mem_rd_y,
  input  logic       mem_rd_mine,
  output logic       rev_we,
  output logic [2:0] rev_x,
  output logic [2:0] rev_y,
  output logic [3:0] rev_count,
  output logic       busy,
  output logic       game_over,
  output logic       win
);

  localparam logic [6:0] SAFE_CELLS = 7'(N * N - MINES);

  typedef enum logic [2:0] {IDLE, CHECK, DECIDE, SCAN, WRITE, LOST, WON} state_t;

  state_t      state, next_state;
  logic [63:0] revealed;
  logic [6:0]  rev_cnt;
  logic [6:0]  rev_cnt_next;
  logic [2:0]  k;
  logic [3:0]  acc;
  logic        inb_d;
  logic [2:0]  tgt_x, tgt_y;
  logic [3:0]  dx, dy, nb_x, nb_y;
  logic        nb_in;
  logic        cur_revealed;
  logic        sel_ok;
  logic [3:0]  mine_add;

  assign cur_revealed = revealed[{casilla_y, casilla_x}];
  assign sel_ok       = sel && !cur_revealed;
  assign rev_cnt_next = rev_cnt + 7'd1;
  assign mine_add     = {3'b000, inb_d & mem_rd_mine};
  assign rev_x        = tgt_x;
  assign rev_y        = tgt_y;

  // Offsets are 4-bit two's complement; bit 3 of the sum flags -1 or 8, i.e. off-board.
  always_comb begin
    dx = 4'h1;
    dy = 4'h1;
    case (k)
      3'd0:    begin dx = 4'hF; dy = 4'hF; end
      3'd1:    begin dx = 4'h0; dy = 4'hF; end
      3'd2:    begin dx = 4'h1; dy = 4'hF; end
      3'd3:    begin dx = 4'hF; dy = 4'h0; end
      3'd4:    begin dx = 4'h1; dy = 4'h0; end
      3'd5:    begin dx = 4'hF; dy = 4'h1; end
      3'd6:    begin dx = 4'h0; dy = 4'h1; end
      default: begin dx = 4'h1; dy = 4'h1; end
    endcase
    nb_x  = {1'b0, tgt_x} + dx;
    nb_y  = {1'b0, tgt_y} + dy;
    nb_in = !nb_x[3] && !nb_y[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_rd_en  = 1'b0;
    mem_rd_x   = 3'd0;
    mem_rd_y   = 3'd0;
    rev_we     = 1'b0;
    rev_count  = 4'd0;
    case (state)
      IDLE:   if (sel_ok) next_state = CHECK;
      CHECK: begin
        mem_rd_en  = 1'b1;
        mem_rd_x   = tgt_x;
        mem_rd_y   = tgt_y;
        next_state = DECIDE;
      end
      DECIDE: next_state = mem_rd_mine ? LOST : SCAN;
      SCAN: begin
        if (nb_in) begin
          mem_rd_en = 1'b1;
          mem_rd_x  = nb_x[2:0];
          mem_rd_y  = nb_y[2:0];
        end
        if (k == 3'd7) next_state = WRITE;
      end
      WRITE: begin
        rev_we     = !restart;
        rev_count  = acc + mine_add;
        next_state = (rev_cnt_next == SAFE_CELLS) ? WON : IDLE;
      end
      default: next_state = state;
    endcase
    if (restart) next_state = IDLE;
  end

  // Cursor, reveal datapath and sticky status; restart behaves like a synchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      casilla_x <= 3'd0;
      casilla_y <= 3'd0;
      tgt_x     <= 3'd0;
      tgt_y     <= 3'd0;
      revealed  <= '0;
      rev_cnt   <= 7'd0;
      k         <= 3'd0;
      acc       <= 4'd0;
      inb_d     <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else if (restart) begin
      casilla_x <= 3'd0;
      casilla_y <= 3'd0;
      revealed  <= '0;
      rev_cnt   <= 7'd0;
      k         <= 3'd0;
      acc       <= 4'd0;
      inb_d     <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      inb_d <= (state == SCAN) && nb_in;
      busy  <= (next_state == CHECK) || (next_state == DECIDE) ||
               (next_state == SCAN)  || (next_state == WRITE);
      case (state)
        IDLE: begin
          if (sel_ok) begin
            tgt_x <= casilla_x;
            tgt_y <= casilla_y;
          end else if (mv_up)    casilla_y <= casilla_y - 3'd1;
          else if (mv_down)      casilla_y <= casilla_y + 3'd1;
          else if (mv_left)      casilla_x <= casilla_x - 3'd1;
          else if (mv_right)     casilla_x <= casilla_x + 3'd1;
        end
        DECIDE: begin
          acc <= 4'd0;
          k   <= 3'd0;
        end
        SCAN: begin
          acc <= acc + mine_add;
          k   <= k + 3'd1;
        end
        WRITE: begin
          revealed[{tgt_y, tgt_x}] <= 1'b1;
          rev_cnt                  <= rev_cnt_next;
        end
        default: ;
      endcase
      if (next_state == LOST) game_over <= 1'b1;
      if (next_state == WON)  win       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_board_reveal_ctrl.sv
// Randomized bench for board_reveal_ctrl: a mine-board model and a cursor/game
// model predict cursor moves, reveal timing, neighbour counts and lose/win.
module tb_board_reveal_ctrl;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0;
  logic       sel = 1'b0, restart = 1'b0, mem_rd_mine = 1'b0;
  logic [2:0] casilla_x, casilla_y, mem_rd_x, mem_rd_y, rev_x, rev_y;
  logic       mem_rd_en, rev_we, busy, game_over, win;
  logic [3:0] rev_count;

  int n_checks = 0, n_fail = 0;
  bit mine_map[64];
  bit mrev[64];
  int cx, cy, mcnt;
  bit mlost, mwon;

  board_reveal_ctrl #(.N(8), .MINES(10)) dut (
    .clk(clk), .rst_n(rst_n), .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left),
    .mv_right(mv_right), .sel(sel), .restart(restart), .casilla_x(casilla_x),
    .casilla_y(casilla_y), .mem_rd_en(mem_rd_en), .mem_rd_x(mem_rd_x), .mem_rd_y(mem_rd_y),
    .mem_rd_mine(mem_rd_mine), .rev_we(rev_we), .rev_x(rev_x), .rev_y(rev_y),
    .rev_count(rev_count), .busy(busy), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  // Bitmap memory: data one cycle after the strobe, noise when not strobed.
  always @(posedge clk)
    mem_rd_mine <= mem_rd_en ? mine_map[int'({mem_rd_y, mem_rd_x})] : 1'($urandom);

  function automatic int neighbours(input int x, input int y, input bit count_cells);
    int n = 0;
    for (int ddy = -1; ddy <= 1; ddy++)
      for (int ddx = -1; ddx <= 1; ddx++)
        if ((ddx != 0 || ddy != 0) && x + ddx >= 0 && x + ddx < 8 && y + ddy >= 0 && y + ddy < 8)
          n += count_cells ? 1 : int'(mine_map[(y + ddy) * 8 + x + ddx]);
    return n;
  endfunction

  function automatic void model_reset();
    cx = 0; cy = 0; mcnt = 0; mlost = 0; mwon = 0;
    foreach (mrev[i]) mrev[i] = 0;
  endfunction

  function automatic void clear_board();
    foreach (mine_map[i]) mine_map[i] = 0;
  endfunction

  task automatic do_move(input bit u, input bit d, input bit l, input bit r);
    @(negedge clk); mv_up = u; mv_down = d; mv_left = l; mv_right = r;
    @(negedge clk); mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0;
    if (!mlost && !mwon) begin
      if (u)      cy = (cy + 7) % 8;
      else if (d) cy = (cy + 1) % 8;
      else if (l) cx = (cx + 7) % 8;
      else if (r) cx = (cx + 1) % 8;
    end
    n_checks++;
    if (casilla_x !== 3'(cx) || casilla_y !== 3'(cy)) begin
      n_fail++;
      $display("[TB] FAIL cursor: got (%0d,%0d) expected (%0d,%0d)", casilla_x, casilla_y, cx, cy);
    end
  endtask

  task automatic goto(input int x, input int y);
    while (cx != x) do_move(0, 0, 0, 1);
    while (cy != y) do_move(0, 1, 0, 0);
  endtask

  task automatic do_restart();
    @(negedge clk); restart = 1;
    @(negedge clk); restart = 0;
    model_reset();
    n_checks++;
    if (casilla_x !== 0 || casilla_y !== 0 || busy !== 0 || game_over !== 0 || win !== 0) begin
      n_fail++;
      $display("[TB] FAIL restart: got xy=(%0d,%0d) busy=%0b go=%0b win=%0b expected all 0",
               casilla_x, casilla_y, busy, game_over, win);
    end
  endtask

  // Issue sel at the cursor and follow the reveal cycle by cycle (c = cycles after the sel edge).
  task automatic do_reveal(input bit with_down);
    int idx, exp_cnt, exp_reads, reads;
    bit hit, exp_busy;
    idx = cy * 8 + cx;
    hit = mine_map[idx];
    exp_cnt = neighbours(cx, cy, 0);
    exp_reads = neighbours(cx, cy, 1);
    reads = 0;
    @(negedge clk); sel = 1; mv_down = with_down;
    @(negedge clk); sel = 0; mv_down = 0;
    if (mrev[idx] || mlost || mwon) begin
      for (int c = 1; c <= 3; c++) begin
        n_checks++;
        if (busy !== 0 || mem_rd_en !== 0 || rev_we !== 0) begin
          n_fail++;
          $display("[TB] FAIL ignored_sel c%0d: got busy=%0b rd=%0b we=%0b expected 0", c, busy, mem_rd_en, rev_we);
        end
        @(negedge clk);
      end
      return;
    end
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      exp_busy = hit ? (c <= 2) : (c <= 11);
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++; $display("[TB] FAIL busy c%0d: got %0b expected %0b", c, busy, exp_busy);
      end
      n_checks++;
      if (rev_we !== (!hit && c == 11)) begin
        n_fail++; $display("[TB] FAIL rev_we c%0d: got %0b expected %0b", c, rev_we, !hit && c == 11);
      end
      if (c == 1) begin
        n_checks++;
        if (mem_rd_en !== 1 || mem_rd_x !== 3'(cx) || mem_rd_y !== 3'(cy)) begin
          n_fail++; $display("[TB] FAIL check_read: got en=%0b (%0d,%0d) expected 1 (%0d,%0d)",
                             mem_rd_en, mem_rd_x, mem_rd_y, cx, cy);
        end
      end
      if (hit && c >= 2) begin
        n_checks++;
        if (mem_rd_en !== 0) begin
          n_fail++; $display("[TB] FAIL read_after_hit c%0d: got %0b expected 0", c, mem_rd_en);
        end
      end
      if (hit && c >= 3) begin
        n_checks++;
        if (game_over !== 1) begin
          n_fail++; $display("[TB] FAIL game_over c%0d: got %0b expected 1", c, game_over);
        end
      end
      if (!hit && c >= 3 && c <= 10 && mem_rd_en === 1) begin
        reads++;
        n_checks++;
        if ((int'(mem_rd_x) - cx) * (int'(mem_rd_x) - cx) > 1 ||
            (int'(mem_rd_y) - cy) * (int'(mem_rd_y) - cy) > 1 ||
            (int'(mem_rd_x) == cx && int'(mem_rd_y) == cy)) begin
          n_fail++; $display("[TB] FAIL scan_addr c%0d: got (%0d,%0d) expected a neighbour of (%0d,%0d)",
                             c, mem_rd_x, mem_rd_y, cx, cy);
        end
      end
      if (!hit && c == 11) begin
        n_checks++;
        if (rev_count !== 4'(exp_cnt) || rev_x !== 3'(cx) || rev_y !== 3'(cy)) begin
          n_fail++; $display("[TB] FAIL rev_data: got cnt=%0d (%0d,%0d) expected cnt=%0d (%0d,%0d)",
                             rev_count, rev_x, rev_y, exp_cnt, cx, cy);
        end
        n_checks++;
        if (reads != exp_reads) begin
          n_fail++; $display("[TB] FAIL scan_reads: got %0d expected %0d", reads, exp_reads);
        end
        n_checks++;
        if (casilla_x !== 3'(cx) || casilla_y !== 3'(cy)) begin
          n_fail++; $display("[TB] FAIL cursor_hold: got (%0d,%0d) expected (%0d,%0d)", casilla_x, casilla_y, cx, cy);
        end
        mrev[idx] = 1;
        mcnt++;
        if (mcnt == 54) mwon = 1;
      end
    end
    if (hit) mlost = 1;
    n_checks++;
    if (win !== mwon || game_over !== mlost) begin
      n_fail++; $display("[TB] FAIL status: got win=%0b go=%0b expected win=%0b go=%0b", win, game_over, mwon, mlost);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (casilla_x !== 0 || casilla_y !== 0 || mem_rd_en !== 0 || rev_we !== 0 || busy !== 0 ||
        game_over !== 0 || win !== 0 || mem_rd_x !== 0 || mem_rd_y !== 0 || rev_x !== 0 ||
        rev_y !== 0 || rev_count !== 0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got a nonzero output expected all 0");
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_moves();
    int p;
    do_move(0, 0, 1, 0);
    do_move(1, 0, 0, 0);
    n_checks++;
    if (casilla_x !== 7 || casilla_y !== 7) begin
      n_fail++; $display("[TB] FAIL wrap_to_77: got (%0d,%0d) expected (7,7)", casilla_x, casilla_y);
    end
    do_move(0, 0, 0, 1);
    n_checks++;
    if (casilla_x !== 0 || casilla_y !== 7) begin
      n_fail++; $display("[TB] FAIL wrap_to_07: got (%0d,%0d) expected (0,7)", casilla_x, casilla_y);
    end
    for (int i = 0; i < 24; i++) begin
      p = int'($urandom_range(0, 15));
      do_move(p[3], p[2], p[1], p[0]);
    end
  endtask

  task automatic test_simultaneous();
    clear_board();
    mine_map[1] = 1; mine_map[8] = 1; mine_map[9] = 1;
    do_restart();
    goto(3, 3);
    do_move(1, 0, 0, 1);
    n_checks++;
    if (casilla_x !== 3 || casilla_y !== 2) begin
      n_fail++; $display("[TB] FAIL up_right: got (%0d,%0d) expected (3,2)", casilla_x, casilla_y);
    end
    do_reveal(1);
  endtask

  task automatic test_corner_reveal();
    do_restart();
    do_reveal(0);
  endtask

  task automatic test_centre_reveal();
    clear_board();
    for (int y = 3; y <= 5; y++)
      for (int x = 3; x <= 5; x++)
        if (x != 4 || y != 4) mine_map[y * 8 + x] = 1;
    do_restart();
    goto(4, 4);
    do_reveal(0);
    do_reveal(0);
  endtask

  task automatic test_mine_hit();
    do_restart();
    goto(3, 3);
    do_reveal(0);
    do_move(0, 0, 1, 0);
    do_move(0, 1, 0, 0);
    do_reveal(0);
    do_restart();
  endtask

  task automatic test_win();
    int placed, r;
    clear_board();
    placed = 0;
    while (placed < 10) begin
      r = int'($urandom_range(0, 63));
      if (!mine_map[r]) begin mine_map[r] = 1; placed++; end
    end
    do_restart();
    for (int i = 0; i < 64; i++)
      if (!mine_map[i]) begin
        goto(i % 8, i / 8);
        do_reveal(0);
      end
    do_move(1, 0, 0, 0);
  endtask

  task automatic test_restart_mid_scan();
    int first, second;
    first = -1; second = -1;
    do_restart();
    for (int i = 0; i < 64; i++)
      if (!mine_map[i]) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    goto(first % 8, first / 8);
    do_reveal(0);
    goto(second % 8, second / 8);
    @(negedge clk); sel = 1;
    @(negedge clk); sel = 0;
    repeat (4) @(negedge clk);
    restart = 1;
    @(negedge clk); restart = 0;
    model_reset();
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (rev_we !== 0 || busy !== 0 || casilla_x !== 0 || casilla_y !== 0) begin
        n_fail++; $display("[TB] FAIL abort c%0d: got we=%0b busy=%0b (%0d,%0d) expected 0 0 (0,0)",
                           c, rev_we, busy, casilla_x, casilla_y);
      end
      @(negedge clk);
    end
    goto(first % 8, first / 8);
    do_reveal(0);
  endtask

  initial begin
    test_reset();
    test_moves();
    test_simultaneous();
    test_corner_reveal();
    test_centre_reveal();
    test_mine_hit();
    test_win();
    test_restart_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
